// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor / resolver slice:
// funct3 encodings, 2-bit counter type and the BTB entry layout.
package branch_pkg;

    localparam int BP_W       = 32;
    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_W - BP_IDX_W - 2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_W-1:0]     target;
        ctr2_t               ctr;
    } btb_entry_t;

    // Saturating step of a 2-bit direction counter.
    function automatic ctr2_t ctr_step(input ctr2_t ctr, input logic taken);
        ctr2_t res;
        res = ctr;
        if (taken && ctr != CTR_ST) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != CTR_SNT) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB with one combinational fetch read port and one clocked
// training port; training is a read-modify-write of the addressed entry.
module btb_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output btb_entry_t          rd_entry_o,
    input  logic                upd_en_i,
    input  logic                upd_jal_i,
    input  logic                upd_taken_i,
    input  logic [IDX_W-1:0]    upd_idx_i,
    input  logic [BP_TAG_W-1:0] upd_tag_i,
    input  logic [BP_W-1:0]     upd_target_i
);

    btb_entry_t mem_reg [ENTRIES];
    btb_entry_t cur_entry;
    btb_entry_t entry_next;
    logic       upd_hit;

    assign rd_entry_o = mem_reg[rd_idx_i];
    assign cur_entry  = mem_reg[upd_idx_i];
    assign upd_hit    = cur_entry.valid && (cur_entry.tag == upd_tag_i);

    // A not-taken branch that misses leaves the entry as it was.
    always_comb begin
        entry_next = cur_entry;
        if (upd_jal_i) begin
            entry_next = '{valid: 1'b1, tag: upd_tag_i, target: upd_target_i, ctr: CTR_ST};
        end else if (upd_hit) begin
            entry_next.ctr = ctr_step(cur_entry.ctr, upd_taken_i);
            if (upd_taken_i) begin
                entry_next.target = upd_target_i;
            end
        end else if (upd_taken_i) begin
            entry_next = '{valid: 1'b1, tag: upd_tag_i, target: upd_target_i, ctr: CTR_WT};
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mem_reg[gi] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
                end else if (upd_en_i && upd_idx_i == GI_IDX) begin
                    mem_reg[gi] <= entry_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/branch_predict_resolve.sv
// Fetch-side BTB prediction plus execute-side branch/JAL resolution,
// mispredict redirect, table training and resolution statistics.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int W       = BP_W,
    parameter int ENTRIES = BP_ENTRIES
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] pc_f_i,
    output logic         pred_taken_f_o,
    output logic [W-1:0] pred_target_f_o,
    input  logic         valid_x_i,
    input  logic         stall_x_i,
    input  logic         is_branch_x_i,
    input  logic         is_jal_x_i,
    input  logic [2:0]   funct3_x_i,
    input  logic [W-1:0] pc_x_i,
    input  logic [W-1:0] target_x_i,
    input  logic         pred_taken_x_i,
    input  logic [W-1:0] pred_target_x_i,
    input  logic         equal_i,
    input  logic         lessthan_i,
    output logic         branch_unsigned_o,
    output logic         taken_x_o,
    output logic         mispredict_x_o,
    output logic [W-1:0] redirect_pc_x_o,
    output logic [31:0]  branch_cnt_o,
    output logic [31:0]  mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = W - IDX_W - 2;

    btb_entry_t       f_entry;
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic             active;
    logic             cond_ok;
    logic             cond_taken;
    logic             jal_act;
    logic             br_act;
    logic             counted;
    logic             taken;
    logic             mispredict;

    logic [31:0]      branch_cnt_reg;
    logic [31:0]      mispred_cnt_reg;

    assign f_idx = pc_f_i[IDX_W+1:2];
    assign f_tag = pc_f_i[W-1:IDX_W+2];
    assign f_hit = f_entry.valid && (f_entry.tag == f_tag);

    assign pred_taken_f_o  = f_hit && f_entry.ctr[1];
    assign pred_target_f_o = pred_taken_f_o ? f_entry.target : pc_f_i + W'(4);

    assign branch_unsigned_o = funct3_x_i[1];

    // Gating with rst_ni keeps the resolution outputs quiet while reset is held.
    assign active = rst_ni && valid_x_i && !stall_x_i;

    always_comb begin
        cond_ok    = 1'b1;
        cond_taken = 1'b0;
        case (funct3_x_i)
            F3_BEQ:           cond_taken = equal_i;
            F3_BNE:           cond_taken = !equal_i;
            F3_BLT, F3_BLTU:  cond_taken = lessthan_i;
            F3_BGE, F3_BGEU:  cond_taken = !lessthan_i;
            default:          cond_ok    = 1'b0;
        endcase
    end

    assign jal_act = active && is_jal_x_i;
    assign br_act  = active && is_branch_x_i && !is_jal_x_i && cond_ok;
    assign counted = jal_act || br_act;
    assign taken   = jal_act || (br_act && cond_taken);

    assign mispredict = counted &&
                        ((pred_taken_x_i != taken) ||
                         (taken && (pred_target_x_i != target_x_i)));

    assign taken_x_o       = taken;
    assign mispredict_x_o  = mispredict;
    assign redirect_pc_x_o = taken ? target_x_i : pc_x_i + W'(4);

    btb_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rd_idx_i     (f_idx),
        .rd_entry_o   (f_entry),
        .upd_en_i     (counted),
        .upd_jal_i    (jal_act),
        .upd_taken_i  (taken),
        .upd_idx_i    (pc_x_i[IDX_W+1:2]),
        .upd_tag_i    (pc_x_i[W-1:IDX_W+2]),
        .upd_target_i (target_x_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (counted && branch_cnt_reg != '1) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (mispredict && mispred_cnt_reg != '1) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_reg;
    assign mispred_cnt_o = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: prediction, resolution,
// training, stall, wrap and mid-stream reset.
module tb_branch_predict_resolve;
    import branch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_f_i;
    logic        pred_taken_f_o;
    logic [31:0] pred_target_f_o;
    logic        valid_x_i;
    logic        stall_x_i;
    logic        is_branch_x_i;
    logic        is_jal_x_i;
    logic [2:0]  funct3_x_i;
    logic [31:0] pc_x_i;
    logic [31:0] target_x_i;
    logic        pred_taken_x_i;
    logic [31:0] pred_target_x_i;
    logic        equal_i;
    logic        lessthan_i;
    logic        branch_unsigned_o;
    logic        taken_x_o;
    logic        mispredict_x_o;
    logic [31:0] redirect_pc_x_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    branch_predict_resolve dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .pc_f_i            (pc_f_i),
        .pred_taken_f_o    (pred_taken_f_o),
        .pred_target_f_o   (pred_target_f_o),
        .valid_x_i         (valid_x_i),
        .stall_x_i         (stall_x_i),
        .is_branch_x_i     (is_branch_x_i),
        .is_jal_x_i        (is_jal_x_i),
        .funct3_x_i        (funct3_x_i),
        .pc_x_i            (pc_x_i),
        .target_x_i        (target_x_i),
        .pred_taken_x_i    (pred_taken_x_i),
        .pred_target_x_i   (pred_target_x_i),
        .equal_i           (equal_i),
        .lessthan_i        (lessthan_i),
        .branch_unsigned_o (branch_unsigned_o),
        .taken_x_o         (taken_x_o),
        .mispredict_x_o    (mispredict_x_o),
        .redirect_pc_x_o   (redirect_pc_x_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic ex_idle();
        valid_x_i       = 1'b0;
        stall_x_i       = 1'b0;
        is_branch_x_i   = 1'b0;
        is_jal_x_i      = 1'b0;
        funct3_x_i      = 3'b000;
        pc_x_i          = 32'h0;
        target_x_i      = 32'h0;
        pred_taken_x_i  = 1'b0;
        pred_target_x_i = 32'h0;
        equal_i         = 1'b0;
        lessthan_i      = 1'b0;
    endtask

    task automatic ex_set(input logic br, input logic jal, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt,
                          input logic eq, input logic lt);
        valid_x_i       = 1'b1;
        stall_x_i       = 1'b0;
        is_branch_x_i   = br;
        is_jal_x_i      = jal;
        funct3_x_i      = f3;
        pc_x_i          = pc;
        target_x_i      = tgt;
        pred_taken_x_i  = pt;
        pred_target_x_i = ptgt;
        equal_i         = eq;
        lessthan_i      = lt;
        #1;
    endtask

    // Clock the pending resolution in, then return EX to idle.
    task automatic tick();
        @(posedge clk_i);
        #2;
        ex_idle();
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic exp_taken, input logic [31:0] exp_tgt);
        pc_f_i = pc;
        #1;
        chk({tag, "_ptk"}, 32'(pred_taken_f_o), 32'(exp_taken));
        chk({tag, "_ptg"}, pred_target_f_o, exp_tgt);
    endtask

    task automatic res(input string tag, input logic exp_taken, input logic exp_mis,
                       input logic [31:0] exp_redir);
        chk({tag, "_tk"}, 32'(taken_x_o), 32'(exp_taken));
        chk({tag, "_mis"}, 32'(mispredict_x_o), 32'(exp_mis));
        if (exp_mis) chk({tag, "_rpc"}, redirect_pc_x_o, exp_redir);
    endtask

    task automatic cnts(input string tag, input logic [31:0] b, input logic [31:0] m);
        chk({tag, "_bcnt"}, branch_cnt_o, b);
        chk({tag, "_mcnt"}, mispred_cnt_o, m);
    endtask

    initial begin
        rst_ni = 1'b0;
        pc_f_i = 32'h100;
        ex_idle();
        repeat (2) @(posedge clk_i);
        #2;
        fetch("rst", 32'h100, 1'b0, 32'h104);
        res("rst", 1'b0, 1'b0, 32'h0);
        cnts("rst", 32'd0, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;

        // BEQ taken, predicted NT; same-index fetch sees the pre-update entry
        pc_f_i = 32'h100;
        ex_set(1'b1, 1'b0, F3_BEQ, 32'h100, 32'h180, 1'b0, 32'h104, 1'b1, 1'b0);
        res("beq", 1'b1, 1'b1, 32'h180);
        fetch("rbw", 32'h100, 1'b0, 32'h104);
        tick();
        fetch("beq_trn", 32'h100, 1'b1, 32'h180);
        cnts("beq", 32'd1, 32'd1);

        // BLTU not taken, correctly predicted
        ex_set(1'b1, 1'b0, F3_BLTU, 32'h144, 32'h1C0, 1'b0, 32'h148, 1'b0, 1'b0);
        chk("bltu_uns", 32'(branch_unsigned_o), 32'd1);
        res("bltu", 1'b0, 1'b0, 32'h0);
        tick();
        cnts("bltu", 32'd2, 32'd1);
        fetch("bltu_f", 32'h144, 1'b0, 32'h148);

        // Four taken BNE at 0x200 (same index as 0x100, new tag)
        ex_set(1'b1, 1'b0, F3_BNE, 32'h200, 32'h280, 1'b0, 32'h204, 1'b0, 1'b0);
        res("bne1", 1'b1, 1'b1, 32'h280);
        tick();
        ex_set(1'b1, 1'b0, F3_BNE, 32'h200, 32'h280, 1'b1, 32'h280, 1'b0, 1'b0);
        res("bne2", 1'b1, 1'b0, 32'h0);
        tick();
        ex_set(1'b1, 1'b0, F3_BNE, 32'h200, 32'h280, 1'b1, 32'h280, 1'b0, 1'b0);
        res("bne3", 1'b1, 1'b0, 32'h0);
        tick();
        ex_set(1'b1, 1'b0, F3_BNE, 32'h200, 32'h280, 1'b1, 32'h280, 1'b0, 1'b0);
        res("bne4", 1'b1, 1'b0, 32'h0);
        tick();
        fetch("bne_f", 32'h200, 1'b1, 32'h280);
        fetch("evict", 32'h100, 1'b0, 32'h104);
        cnts("bne4", 32'd6, 32'd2);

        // BNE not taken: counter 11 -> 10, still predicts taken
        ex_set(1'b1, 1'b0, F3_BNE, 32'h200, 32'h280, 1'b1, 32'h280, 1'b1, 1'b0);
        res("bne5", 1'b0, 1'b1, 32'h204);
        tick();
        fetch("bne5_f", 32'h200, 1'b1, 32'h280);
        cnts("bne5", 32'd7, 32'd3);

        // JAL with wrong predicted target
        ex_set(1'b0, 1'b1, 3'b000, 32'h40, 32'h400, 1'b1, 32'h3FC, 1'b0, 1'b0);
        res("jal", 1'b1, 1'b1, 32'h400);
        tick();
        fetch("jal_f", 32'h40, 1'b1, 32'h400);
        cnts("jal", 32'd8, 32'd4);

        // Two NT BEQ at 0x40: strong-taken needs two steps to flip
        ex_set(1'b1, 1'b0, F3_BEQ, 32'h40, 32'h400, 1'b0, 32'h44, 1'b0, 1'b0);
        res("beqnt1", 1'b0, 1'b0, 32'h0);
        tick();
        fetch("beqnt1_f", 32'h40, 1'b1, 32'h400);
        ex_set(1'b1, 1'b0, F3_BEQ, 32'h40, 32'h400, 1'b0, 32'h44, 1'b0, 1'b0);
        tick();
        fetch("beqnt2_f", 32'h40, 1'b0, 32'h44);
        cnts("beqnt", 32'd10, 32'd4);

        // Reserved funct3 010: ignored entirely
        ex_set(1'b1, 1'b0, 3'b010, 32'h40, 32'h500, 1'b1, 32'h500, 1'b1, 1'b1);
        res("f3_010", 1'b0, 1'b0, 32'h0);
        tick();
        cnts("f3_010", 32'd10, 32'd4);

        // Valid non-control instruction
        ex_set(1'b0, 1'b0, F3_BEQ, 32'h80, 32'h600, 1'b1, 32'h600, 1'b1, 1'b0);
        res("alu", 1'b0, 1'b0, 32'h0);
        tick();

        // Stalled mispredicting branch: no update, no count
        ex_set(1'b1, 1'b0, F3_BEQ, 32'h300, 32'h380, 1'b0, 32'h304, 1'b1, 1'b0);
        stall_x_i = 1'b1;
        #1;
        res("stall", 1'b0, 1'b0, 32'h0);
        tick();
        fetch("stall_f", 32'h300, 1'b0, 32'h304);
        cnts("stall", 32'd10, 32'd4);

        // PC+4 wraps to 0
        ex_set(1'b1, 1'b0, F3_BEQ, 32'hFFFF_FFFC, 32'h1000, 1'b1, 32'h1000, 1'b0, 1'b0);
        res("wrap", 1'b0, 1'b1, 32'h0000_0000);
        tick();
        cnts("wrap", 32'd11, 32'd5);
        fetch("wrap_f", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Retrain 0x40 then reset mid-cycle with a mispredict in flight
        ex_set(1'b0, 1'b1, 3'b000, 32'h40, 32'h400, 1'b0, 32'h44, 1'b0, 1'b0);
        tick();
        fetch("pre_rst", 32'h40, 1'b1, 32'h400);
        cnts("pre_rst", 32'd12, 32'd6);
        ex_set(1'b1, 1'b0, F3_BEQ, 32'h100, 32'h180, 1'b0, 32'h104, 1'b1, 1'b0);
        res("pre_rst", 1'b1, 1'b1, 32'h180);
        rst_ni = 1'b0;
        #1;
        res("mid_rst", 1'b0, 1'b0, 32'h0);
        cnts("mid_rst", 32'd0, 32'd0);
        fetch("mid_rst", 32'h40, 1'b0, 32'h44);
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;
        fetch("post_rst", 32'h100, 1'b0, 32'h104);
        cnts("post_rst", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
